// File: rtl/hdlc_tx_arbiter.sv
// rtl/hdlc_tx_arbiter.sv - round-robin frame arbiter driving the Hdlc host register bus
// Optional watchdog: define TXARB_WATCHDOG_EN.
module hdlc_tx_arbiter #(
   parameter int N_REQ     = 4,
   parameter int MAX_BYTES = 126,
   parameter int HOLDOFF   = 4,
   parameter int WDOG_CYC  = 1024
) (
   input  logic               Clk,
   input  logic               Rst,
   input  logic [N_REQ-1:0]   Req_Valid,
   input  logic [8*N_REQ-1:0] Req_Data,
   input  logic [N_REQ-1:0]   Req_Last,
   output logic [N_REQ-1:0]   Req_Ready,
   output logic [N_REQ-1:0]   Grant,
   output logic [2:0]         Address,
   output logic               WriteEnable,
   output logic               ReadEnable,
   output logic [7:0]         DataIn,
   input  logic [7:0]         DataOut,
   output logic               Busy,
   output logic               Frame_Sent,
   output logic               Ovf_Err,
   output logic               Wdog_Err
);
   localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int CW = $clog2(MAX_BYTES + 1);
   localparam int HW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

   typedef enum logic [2:0] {
      S_IDLE, S_POLL_RD, S_POLL_CHK, S_ARB, S_LOAD, S_START, S_HOLD
   } state_t;

   state_t           state, state_nx;
   logic [PW-1:0]    ptr, ptr_nx, gidx, gidx_nx, pick, gidx_inc;
   logic [CW-1:0]    cnt, cnt_nx;
   logic [HW-1:0]    hcnt, hcnt_nx;
   logic             ovf_seen, ovf_seen_nx, found;
   logic [N_REQ-1:0] grant_nx;
   logic [2:0]       addr_nx;
   logic             we_nx, re_nx, fs_nx, ovf_nx, wdog_nx;
   logic [7:0]       din_nx, byte_in;
   logic             accept, last_in, wdog_fire;
   logic             unused_bits;

   assign Busy      = (state != S_IDLE);
   assign Req_Ready = (state == S_LOAD) ? Grant : '0;
   assign accept    = |(Req_Valid & Req_Ready);
   assign byte_in   = Req_Data[8*gidx +: 8];
   assign last_in   = Req_Last[gidx];
   assign gidx_inc  = (gidx == PW'(N_REQ - 1)) ? '0 : gidx + 1'b1;

`ifdef TXARB_WATCHDOG_EN
   localparam int WW = $clog2(WDOG_CYC + 1);
   logic [WW-1:0] wcnt;

   // Counts stalled LOAD cycles; held at zero outside LOAD so entry starts fresh.
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst)                          wcnt <= '0;
      else if (state != S_LOAD || accept) wcnt <= '0;
      else                               wcnt <= wcnt + 1'b1;
   end
   assign wdog_fire   = (state == S_LOAD) && !accept && (wcnt == WW'(WDOG_CYC - 1));
   assign unused_bits = ^DataOut[7:1];
`else
   assign wdog_fire   = 1'b0;
   assign unused_bits = ^{DataOut[7:1], 32'(WDOG_CYC)};
`endif

   // Rotating priority search starting at the round-robin pointer.
   always_comb begin
      int idx;
      found = 1'b0;
      pick  = '0;
      idx   = 0;
      for (int i = 0; i < N_REQ; i++) begin
         idx = int'(ptr) + i;
         if (idx >= N_REQ) idx = idx - N_REQ;
         if (!found && Req_Valid[idx]) begin
            found = 1'b1;
            pick  = PW'(idx);
         end
      end
   end

   always_comb begin
      state_nx    = state;
      ptr_nx      = ptr;
      gidx_nx     = gidx;
      grant_nx    = Grant;
      cnt_nx      = cnt;
      hcnt_nx     = hcnt;
      ovf_seen_nx = ovf_seen;
      addr_nx     = 3'd0;
      we_nx       = 1'b0;
      re_nx       = 1'b0;
      din_nx      = 8'h00;
      fs_nx       = 1'b0;
      ovf_nx      = 1'b0;
      wdog_nx     = 1'b0;
      case (state)
         S_IDLE: if (|Req_Valid) begin
            state_nx = S_POLL_RD;
            re_nx    = 1'b1;
         end
         S_POLL_RD: state_nx = S_POLL_CHK;
         S_POLL_CHK: if (DataOut[0]) begin
            state_nx = S_ARB;
         end else begin
            state_nx = S_POLL_RD;
            re_nx    = 1'b1;
         end
         S_ARB: if (found) begin
            gidx_nx     = pick;
            grant_nx    = N_REQ'(1) << pick;
            cnt_nx      = '0;
            ovf_seen_nx = 1'b0;
            state_nx    = S_LOAD;
         end else begin
            state_nx = S_IDLE;
         end
         S_LOAD: if (wdog_fire) begin
            we_nx    = 1'b1;
            din_nx   = 8'h04;
            wdog_nx  = 1'b1;
            ptr_nx   = gidx_inc;
            grant_nx = '0;
            hcnt_nx  = '0;
            state_nx = S_HOLD;
         end else if (accept) begin
            // Bytes past MAX_BYTES are still handshaken so the requester can finish its frame.
            if (cnt < CW'(MAX_BYTES)) begin
               we_nx   = 1'b1;
               addr_nx = 3'd1;
               din_nx  = byte_in;
               cnt_nx  = cnt + 1'b1;
            end else if (!ovf_seen) begin
               ovf_nx      = 1'b1;
               ovf_seen_nx = 1'b1;
            end
            if (last_in) state_nx = S_START;
         end
         S_START: begin
            we_nx    = 1'b1;
            din_nx   = 8'h02;
            fs_nx    = 1'b1;
            ptr_nx   = gidx_inc;
            grant_nx = '0;
            hcnt_nx  = '0;
            state_nx = S_HOLD;
         end
         S_HOLD: if (hcnt == HW'(HOLDOFF - 1)) state_nx = S_IDLE;
                 else hcnt_nx = hcnt + 1'b1;
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         state       <= S_IDLE;
         ptr         <= '0;
         gidx        <= '0;
         Grant       <= '0;
         cnt         <= '0;
         hcnt        <= '0;
         ovf_seen    <= 1'b0;
         Address     <= 3'd0;
         WriteEnable <= 1'b0;
         ReadEnable  <= 1'b0;
         DataIn      <= 8'h00;
         Frame_Sent  <= 1'b0;
         Ovf_Err     <= 1'b0;
         Wdog_Err    <= 1'b0;
      end else begin
         state       <= state_nx;
         ptr         <= ptr_nx;
         gidx        <= gidx_nx;
         Grant       <= grant_nx;
         cnt         <= cnt_nx;
         hcnt        <= hcnt_nx;
         ovf_seen    <= ovf_seen_nx;
         Address     <= addr_nx;
         WriteEnable <= we_nx;
         ReadEnable  <= re_nx;
         DataIn      <= din_nx;
         Frame_Sent  <= fs_nx;
         Ovf_Err     <= ovf_nx;
         Wdog_Err    <= wdog_nx;
      end
   end
endmodule

// File: tb/tb_hdlc_tx_arbiter.sv
// tb/tb_hdlc_tx_arbiter.sv - self-checking bench for hdlc_tx_arbiter with a frame-level reference model
module tb_hdlc_tx_arbiter;
   localparam int N    = 4;
   localparam int MAXB = 126;

   logic           Clk = 1'b0;
   logic           Rst = 1'b0;
   logic [N-1:0]   Req_Valid = '0;
   logic [8*N-1:0] Req_Data  = '0;
   logic [N-1:0]   Req_Last  = '0;
   logic [N-1:0]   Req_Ready, Grant;
   logic [2:0]     Address;
   logic           WriteEnable, ReadEnable;
   logic [7:0]     DataIn;
   logic [7:0]     DataOut = 8'h00;
   logic           Busy, Frame_Sent, Ovf_Err, Wdog_Err;

   int checks = 0, errors = 0;

   // Pending bytes per requester, {last, data}; entries in bus_log are {read, addr, data}.
   logic [8:0]   rq [N][$];
   logic [11:0]  bus_log[$], wr_log[$], exp_wr[$];
   logic [N-1:0] grant_log[$], exp_grant[$];
   int exp_ovf, exp_bytes;
   int zero_left = 0;
   bit rand_polls = 0, gaps = 0;
   int fs_cnt = 0, fs_bad = 0, ovf_cnt = 0, wdog_cnt = 0, proto_bad = 0, grant_bad = 0, acc_cnt = 0;
   logic [N-1:0] last_grant = '0, pend = '0;

   hdlc_tx_arbiter #(.N_REQ(N), .MAX_BYTES(MAXB), .HOLDOFF(4), .WDOG_CYC(16)) dut (
      .Clk(Clk), .Rst(Rst), .Req_Valid(Req_Valid), .Req_Data(Req_Data), .Req_Last(Req_Last),
      .Req_Ready(Req_Ready), .Grant(Grant), .Address(Address), .WriteEnable(WriteEnable),
      .ReadEnable(ReadEnable), .DataIn(DataIn), .DataOut(DataOut), .Busy(Busy),
      .Frame_Sent(Frame_Sent), .Ovf_Err(Ovf_Err), .Wdog_Err(Wdog_Err)
   );

   always #5 Clk = ~Clk;

   // Hdlc register model and bus monitor.
   always @(negedge Clk) begin
      if (Rst) begin
         if (WriteEnable && ReadEnable) proto_bad++;
         if (ReadEnable) begin
            bus_log.push_back({1'b1, Address, 8'h00});
            DataOut = (8'($urandom()) & 8'hFE) | ((zero_left == 0) ? 8'h01 : 8'h00);
            if (zero_left > 0) zero_left--;
         end
         if (WriteEnable) begin
            bus_log.push_back({1'b0, Address, DataIn});
            if (rand_polls && Address == 3'd0 && DataIn == 8'h02) zero_left = $urandom_range(0, 3);
         end
         if (Frame_Sent) begin
            fs_cnt++;
            if (!(WriteEnable && Address == 3'd0 && DataIn == 8'h02)) fs_bad++;
         end
         if (Ovf_Err) ovf_cnt++;
         if (Wdog_Err) wdog_cnt++;
         if (Grant != last_grant) begin
            if (Grant != '0) grant_log.push_back(Grant);
            if ($countones(Grant) > 1) grant_bad++;
            last_grant = Grant;
         end
      end
   end

   // Requester driver: retires the byte handshaken at the previous rising edge, then presents the next.
   always @(negedge Clk) begin
      if (!Rst) begin
         pend      = '0;
         Req_Valid = '0;
      end else begin
         for (int i = 0; i < N; i++)
            if (pend[i] && rq[i].size() > 0) begin
               void'(rq[i].pop_front());
               acc_cnt++;
            end
         for (int i = 0; i < N; i++) begin
            if (rq[i].size() == 0) begin
               Req_Valid[i]        = 1'b0;
               Req_Last[i]         = 1'b0;
               Req_Data[8*i +: 8]  = 8'h00;
            end else begin
               Req_Data[8*i +: 8]  = rq[i][0][7:0];
               Req_Last[i]         = rq[i][0][8];
               Req_Valid[i]        = !(gaps && Req_Ready[i] && $urandom_range(0, 3) == 0);
            end
         end
         pend = Req_Valid & Req_Ready;
      end
   end

   task automatic do_reset();
      @(negedge Clk);
      Rst = 1'b0;
      repeat (2) @(negedge Clk);
      for (int i = 0; i < N; i++) rq[i].delete();
      bus_log.delete();
      grant_log.delete();
      fs_cnt = 0; fs_bad = 0; ovf_cnt = 0; wdog_cnt = 0; proto_bad = 0; grant_bad = 0; acc_cnt = 0;
      last_grant = '0; zero_left = 0; rand_polls = 0; gaps = 0;
      #1 Rst = 1'b1;
   endtask

   task automatic add_frame(input int r, input int len);
      for (int k = 0; k < len; k++) rq[r].push_back({(k == len - 1), 8'($urandom())});
   endtask

   function automatic bit queues_empty();
      for (int i = 0; i < N; i++) if (rq[i].size() != 0) return 1'b0;
      return 1'b1;
   endfunction

   task automatic wait_done(input string name, input int budget);
      bit done = 1'b0;
      for (int c = 0; c < budget && !done; c++) begin
         @(negedge Clk);
         #1 done = !Busy && queues_empty();
      end
      repeat (3) @(negedge Clk);
      #1;
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL %s_timeout busy=%0b empty=%0b required idle within %0d cycles", name, Busy, queues_empty(), budget);
      end
   endtask

   task automatic collect_writes();
      wr_log.delete();
      foreach (bus_log[i]) if (!bus_log[i][11]) wr_log.push_back(bus_log[i]);
   endtask

   // Frame-level model: round robin over requesters holding frames, truncation at MAXB bytes.
   task automatic build_model();
      logic [8:0] mq [N][$];
      logic [8:0] b;
      int ptr, w, n;
      for (int i = 0; i < N; i++) mq[i] = rq[i];
      exp_wr.delete();
      exp_grant.delete();
      exp_ovf = 0; exp_bytes = 0; ptr = 0;
      while (1) begin
         w = -1;
         for (int k = 0; k < N; k++)
            if (w < 0 && mq[(ptr + k) % N].size() > 0) w = (ptr + k) % N;
         if (w < 0) break;
         exp_grant.push_back(N'(1) << w);
         n = 0;
         while (1) begin
            b = mq[w].pop_front();
            n++;
            exp_bytes++;
            if (n <= MAXB) exp_wr.push_back({1'b0, 3'd1, b[7:0]});
            else if (n == MAXB + 1) exp_ovf++;
            if (b[8]) break;
         end
         exp_wr.push_back({1'b0, 3'd0, 8'h02});
         ptr = (w + 1) % N;
      end
   endtask

   task automatic test_reset();
      Rst = 1'b0;
      repeat (3) @(negedge Clk);
      #1;
      checks++; if (Grant !== '0 || Req_Ready !== '0) begin errors++; $display("FAIL reset_grant grant=%b ready=%b required 0", Grant, Req_Ready); end
      checks++; if ({Address, WriteEnable, ReadEnable, DataIn} !== 13'h0) begin errors++; $display("FAIL reset_bus addr=%0d we=%b re=%b din=%h required 0", Address, WriteEnable, ReadEnable, DataIn); end
      checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", Busy); end
      checks++; if ({Frame_Sent, Ovf_Err, Wdog_Err} !== 3'b000) begin errors++; $display("FAIL reset_pulses got=%b exp=000", {Frame_Sent, Ovf_Err, Wdog_Err}); end
      Rst = 1'b1;
      repeat (10) @(negedge Clk);
      #1;
      checks++; if (bus_log.size() != 0) begin errors++; $display("FAIL idle_bus_activity got=%0d exp=0", bus_log.size()); end
      checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL idle_busy got=%b exp=0", Busy); end
   endtask

   task automatic test_single_frame();
      logic [11:0] exp [5] = '{12'h800, 12'h1A1, 12'h1B2, 12'h1C3, 12'h002};
      do_reset();
      rq[0].push_back(9'h0A1);
      rq[0].push_back(9'h0B2);
      rq[0].push_back(9'h1C3);
      wait_done("single", 500);
      checks++; if (bus_log.size() != 5) begin errors++; $display("FAIL single_len got=%0d exp=5", bus_log.size()); end
      for (int i = 0; i < 5 && i < bus_log.size(); i++) begin
         checks++;
         if (bus_log[i] !== exp[i]) begin errors++; $display("FAIL single_bus[%0d] got=%h exp=%h", i, bus_log[i], exp[i]); end
      end
      checks++; if (fs_cnt != 1 || fs_bad != 0) begin errors++; $display("FAIL single_frame_sent got=%0d bad=%0d exp=1 bad=0", fs_cnt, fs_bad); end
   endtask

   task automatic test_poll_wait();
      logic [11:0] exp [9] = '{12'h800, 12'h800, 12'h800, 12'h800, 12'h800, 12'h800, 12'h15A, 12'h13C, 12'h002};
      do_reset();
      zero_left = 5;
      rq[2].push_back(9'h05A);
      rq[2].push_back(9'h13C);
      wait_done("poll", 500);
      checks++; if (bus_log.size() != 9) begin errors++; $display("FAIL poll_len got=%0d exp=9", bus_log.size()); end
      for (int i = 0; i < 9 && i < bus_log.size(); i++) begin
         checks++;
         if (bus_log[i] !== exp[i]) begin errors++; $display("FAIL poll_bus[%0d] got=%h exp=%h", i, bus_log[i], exp[i]); end
      end
   endtask

   task automatic test_arbitration();
      do_reset();
      add_frame(0, 1); add_frame(0, 1); add_frame(1, 1); add_frame(3, 1);
      build_model();
      wait_done("arb", 1000);
      checks++; if (grant_log.size() != exp_grant.size()) begin errors++; $display("FAIL arb_grants got=%0d exp=%0d", grant_log.size(), exp_grant.size()); end
      for (int i = 0; i < exp_grant.size() && i < grant_log.size(); i++) begin
         checks++;
         if (grant_log[i] !== exp_grant[i]) begin errors++; $display("FAIL arb_grant[%0d] got=%b exp=%b", i, grant_log[i], exp_grant[i]); end
      end
      collect_writes();
      checks++; if (wr_log != exp_wr) begin errors++; $display("FAIL arb_writes got=%0d entries exp=%0d entries", wr_log.size(), exp_wr.size()); end
      checks++; if (grant_bad != 0 || proto_bad != 0) begin errors++; $display("FAIL arb_protocol grant_bad=%0d proto_bad=%0d exp 0", grant_bad, proto_bad); end
   endtask

   task automatic test_overflow();
      do_reset();
      add_frame(1, MAXB);
      add_frame(2, 130);
      build_model();
      wait_done("ovf", 3000);
      collect_writes();
      checks++; if (wr_log.size() != exp_wr.size()) begin errors++; $display("FAIL ovf_write_count got=%0d exp=%0d", wr_log.size(), exp_wr.size()); end
      checks++; if (wr_log != exp_wr) begin errors++; $display("FAIL ovf_write_data got=%0d entries exp=%0d entries", wr_log.size(), exp_wr.size()); end
      checks++; if (ovf_cnt != exp_ovf) begin errors++; $display("FAIL ovf_pulses got=%0d exp=%0d", ovf_cnt, exp_ovf); end
      checks++; if (acc_cnt != exp_bytes) begin errors++; $display("FAIL ovf_handshakes got=%0d exp=%0d", acc_cnt, exp_bytes); end
      checks++; if (fs_cnt != 2 || fs_bad != 0) begin errors++; $display("FAIL ovf_frame_sent got=%0d bad=%0d exp=2 bad=0", fs_cnt, fs_bad); end
   endtask

   task automatic test_reset_mid_load();
      bit hit = 1'b0;
      do_reset();
      add_frame(0, 40);
      for (int c = 0; c < 500 && !hit; c++) begin
         @(negedge Clk);
         #1 hit = (Grant != '0) && (bus_log.size() >= 6);
      end
      checks++; if (!hit) begin errors++; $display("FAIL midload_reach grant=%b log=%0d required grant and 6 bus ops", Grant, bus_log.size()); end
      #2 Rst = 1'b0;
      #1;
      checks++; if (Grant !== '0 || Req_Ready !== '0 || Busy !== 1'b0 || WriteEnable !== 1'b0) begin
         errors++; $display("FAIL midload_async grant=%b ready=%b busy=%b we=%b required 0", Grant, Req_Ready, Busy, WriteEnable);
      end
   endtask

   task automatic test_random();
      for (int it = 0; it < 4; it++) begin
         do_reset();
         gaps = 1'b1;
         rand_polls = 1'b1;
         for (int r = 0; r < N; r++) begin
            int nf = $urandom_range(0, 2);
            for (int f = 0; f < nf; f++)
               add_frame(r, ($urandom_range(0, 4) == 0) ? $urandom_range(120, 130) : $urandom_range(1, 6));
         end
         if (queues_empty()) add_frame($urandom_range(0, N - 1), 3);
         build_model();
         wait_done("rand", 20000);
         collect_writes();
         checks++; if (wr_log != exp_wr) begin errors++; $display("FAIL rand%0d_writes got=%0d entries exp=%0d entries", it, wr_log.size(), exp_wr.size()); end
         checks++; if (grant_log != exp_grant) begin errors++; $display("FAIL rand%0d_grants got=%0d grants exp=%0d grants", it, grant_log.size(), exp_grant.size()); end
         checks++; if (ovf_cnt != exp_ovf) begin errors++; $display("FAIL rand%0d_ovf got=%0d exp=%0d", it, ovf_cnt, exp_ovf); end
         checks++; if (acc_cnt != exp_bytes) begin errors++; $display("FAIL rand%0d_handshakes got=%0d exp=%0d", it, acc_cnt, exp_bytes); end
         checks++; if (fs_cnt != exp_grant.size() || fs_bad != 0) begin errors++; $display("FAIL rand%0d_frame_sent got=%0d bad=%0d exp=%0d", it, fs_cnt, fs_bad, exp_grant.size()); end
         checks++; if (proto_bad != 0 || grant_bad != 0 || wdog_cnt != 0) begin
            errors++; $display("FAIL rand%0d_protocol proto=%0d grant=%0d wdog=%0d exp 0", it, proto_bad, grant_bad, wdog_cnt);
         end
      end
   endtask

   initial begin
      test_reset();
      test_single_frame();
      test_poll_wait();
      test_arbitration();
      test_overflow();
      test_reset_mid_load();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/hdlc_tx_arbiter.md
Name: hdlc_tx_arbiter

Overview:
Round-robin arbiter and sequencer that shares the single Hdlc transmit channel between N byte-stream frame requesters. It drives the Hdlc host register bus (Address/WriteEnable/ReadEnable/DataIn/DataOut) in place of a CPU:
- polls Tx_SC until the transmitter is idle;
- grants one requester for a whole frame and streams its bytes into Tx_Buff;
- sets Tx_Enable.

It sits between the requester blocks and the Hdlc top level.

Parameters:
N_REQ, 4, number of requesters (2..8).
MAX_BYTES, 126, maximum payload bytes per frame; bytes beyond this are discarded.
HOLDOFF, 4, cycles to wait after Tx_Enable before Tx_SC is polled again.
WDOG_CYC, 1024, stall limit for the optional watchdog.

Ports:
Clk  in  1  system clock, rising edge.
Rst  in  1  asynchronous reset, active-low.
Req_Valid  in  N_REQ  per-requester byte valid.
Req_Data  in  8*N_REQ  per-requester byte; requester i uses bits [8i+7:8i].
Req_Last  in  N_REQ  marks final byte of frame.
Req_Ready  out  N_REQ  per-requester byte accept.
Grant  out  N_REQ  one-hot owner of current frame; 0 when none.
Address  out  3  Hdlc register address.
WriteEnable  out  1  Hdlc register write strobe.
ReadEnable  out  1  Hdlc register read strobe.
DataIn  out  8  Hdlc write data.
DataOut  in  8  Hdlc read data; valid the cycle after ReadEnable.
Busy  out  1  high in every state except IDLE.
Frame_Sent  out  1  one-cycle pulse when Tx_Enable is written.
Ovf_Err  out  1  one-cycle pulse on the first discarded byte of an overlength frame.
Wdog_Err  out  1  one-cycle watchdog pulse; tied 0 when the optional feature is compiled out.

Behaviour:
- Register map used:
  - 0x0 Tx_SC: bit0 Tx_Done (read), bit1 Tx_Enable, bit2 Tx_AbortFrame.
  - 0x1 Tx_Buff (write).
- Reset (Rst=0, asynchronous):
  - all outputs 0; state IDLE;
  - round-robin pointer 0; byte count 0; write pipeline cleared.
- Bus outputs are registered. WriteEnable and ReadEnable are never high in the same cycle.
- States:
  - IDLE: if any Req_Valid -> POLL_RD.
  - POLL_RD: ReadEnable=1, Address=0 for one cycle -> POLL_CHK.
  - POLL_CHK: sample DataOut[0]. If 1 -> ARB, else -> POLL_RD.
  - ARB: pick first Req_Valid at or after the pointer (wrap modulo N_REQ); latch Grant; count=0 -> LOAD. If no Req_Valid remains -> IDLE.
  - LOAD:
    - Req_Ready[g]=1; all other Req_Ready bits are 0.
    - Each byte accepted (Req_Valid[g]&&Req_Ready[g]) with count<MAX_BYTES is written next cycle: WriteEnable=1, Address=1, DataIn=byte. count increments. Throughput is 1 byte/cycle.
    - Accepted bytes with count==MAX_BYTES are consumed, not written. Ovf_Err pulses once per frame.
    - Accepted byte with Req_Last -> START (after its pending write issues).
    - Req_Valid low simply stalls the state.
  - START: WriteEnable=1, Address=0, DataIn=8'h02; Frame_Sent=1; pointer=g+1 (mod N_REQ); Grant=0 -> HOLD.
  - HOLD: count HOLDOFF cycles -> IDLE.
- Boundary conditions:
  - A single-byte frame (Last on first byte) is legal.
  - Exactly MAX_BYTES bytes gives no Ovf_Err.
  - Several requesters valid simultaneously: the lowest index at or after the pointer wins. Arbitration is fair: no requester waits more than N_REQ-1 frames.
  - Grant is never revoked mid-frame except by reset or the watchdog.
  - Reset mid-LOAD leaves partial bytes in the Hdlc buffer; the Hdlc is reset by the same Rst.

Optional Feature:
- Macro: TXARB_WATCHDOG_EN.
- When defined:
  - A counter clears on every accepted byte and on entry to LOAD.
  - If it reaches WDOG_CYC in LOAD: write Tx_SC=8'h04 (abort), pulse Wdog_Err, advance the pointer past g, Grant=0 -> HOLD.
- When undefined: LOAD waits indefinitely; Wdog_Err is constant 0; no counter logic exists.

Test Plan:
1. Reset with Req_Valid=0 -> all outputs 0, Busy=0; after release, no bus activity.
2. Requester 0 sends 3 bytes 0xA1,0xB2,0xC3(Last); Tx_Done=1 -> read at addr 0; writes 0xA1,0xB2,0xC3 to addr 1; then write 0x02 to addr 0; Frame_Sent one pulse.
3. Tx_Done=0 for 5 polls then 1 -> POLL_RD/POLL_CHK alternate 5 times; no Tx_Buff write before Tx_Done=1.
4. Requesters 0,1,3 all valid with 1-byte frames -> Grant order 0001,0010,1000,0001.
5. 130-byte frame -> 126 writes to addr 1; Ovf_Err pulses once at byte 127; all 130 handshakes complete; Tx_Enable is written.
6. TXARB_WATCHDOG_EN, WDOG_CYC=16, requester stalls after 2 bytes -> 16 cycles later write 0x04 to addr 0; Wdog_Err pulse; next requester granted.
